// File: rtl/triplet_loader_pkg.sv
// Shared definitions for triplet_loader and the sample-side debug logic.
// Holds the FSM state codes seen on the debug bus, the debug-bus width and
// the default operand width.
package triplet_loader_pkg;

    localparam int unsigned DBG_W  = 2;
    localparam int unsigned DEF_DW = 8;

    // State codes double as the debug-bus encoding: code == bytes held,
    // with 2'b11 meaning a complete triplet is waiting.
    typedef enum logic [DBG_W-1:0] {
        ST_EMPTY  = 2'b00,
        ST_HAVE_A = 2'b01,
        ST_HAVE_B = 2'b10,
        ST_FULL   = 2'b11
    } state_t;

endpackage

// File: rtl/triplet_loader_tmo.sv
// tmo_counter: idle-cycle counter for a partially assembled triplet.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   clear      : force the count to 0 (has priority over enable)
//   enable     : count one idle cycle
//   expired    : count has reached TMO
module tmo_counter #(
    parameter int unsigned CW  = 5,
    parameter int unsigned TMO = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CW-1:0] r_cnt;
    logic          w_at_limit;

    assign w_at_limit = (r_cnt == CW'(TMO));
    assign expired    = w_at_limit;

    // Count idle cycles; never advances past TMO so it cannot wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable && !w_at_limit) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/triplet_loader.sv
// triplet_loader: assembles three consecutive bytes from a valid/ready
// stream into an {a, b, c} operand triplet for the sample block.
// Ports:
//   clk, rst_n           : clock, async active-low reset
//   in_valid/in_data     : upstream byte stream
//   in_ready             : byte can be accepted (decoded from state only)
//   a, b, c              : assembled operands, stable while out_valid
//   out_valid/out_ready  : triplet handshake to downstream
//   err / err_clr        : sticky timeout flag and its clear
//   e_oe / e / e_in      : shared debug bus carrying the state code
module triplet_loader
    import triplet_loader_pkg::*;
#(
    parameter int unsigned DW  = DEF_DW,
    parameter int unsigned TMO = 16,
    parameter int unsigned CW  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [DW-1:0]    in_data,
    output logic             in_ready,
    output logic [DW-1:0]    a,
    output logic [DW-1:0]    b,
    output logic [DW-1:0]    c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err,
    input  logic             err_clr,
    input  logic             e_oe,
    inout  wire  [DBG_W-1:0] e,
    output logic [DBG_W-1:0] e_in
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [DW-1:0]   r_a;
    logic [DW-1:0]   r_b;
    logic [DW-1:0]   r_c;
    logic            r_err;
    logic [DBG_W-1:0] r_e_in;

    logic            w_accept;
    logic            w_partial;
    logic            w_expired;
    logic            w_ld_a;
    logic            w_ld_b;
    logic            w_ld_c;
    logic            w_err_set;

    assign in_ready  = (r_state != ST_FULL);
    assign out_valid = (r_state == ST_FULL);
    assign w_accept  = in_valid & in_ready;
    assign w_partial = (r_state == ST_HAVE_A) || (r_state == ST_HAVE_B);

    assign a    = r_a;
    assign b    = r_b;
    assign c    = r_c;
    assign err  = r_err;
    assign e_in = r_e_in;

    // Debug bus: drive the state code only while the master grants us the bus.
    assign e = e_oe ? DBG_W'(r_state) : {DBG_W{1'bz}};

    // Counter is held at 0 outside the partial states and restarts on
    // every accepted byte and on the timeout itself.
    tmo_counter #(
        .CW  (CW),
        .TMO (TMO)
    ) u_tmo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (w_accept | ~w_partial | w_expired),
        .enable  (w_partial),
        .expired (w_expired)
    );

    // Next-state and load decode; an accept always takes priority over timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_ld_a      = 1'b0;
        w_ld_b      = 1'b0;
        w_ld_c      = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_ld_a      = 1'b1;
                    w_state_nxt = ST_HAVE_A;
                end
            end
            ST_HAVE_A: begin
                if (w_accept) begin
                    w_ld_b      = 1'b1;
                    w_state_nxt = ST_HAVE_B;
                end else if (w_expired) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_HAVE_B: begin
                if (w_accept) begin
                    w_ld_c      = 1'b1;
                    w_state_nxt = ST_FULL;
                end else if (w_expired) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_ready) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // State, operand, error and debug-sample registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
            r_err   <= 1'b0;
            r_e_in  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_ld_a) r_a <= in_data;
            if (w_ld_b) r_b <= in_data;
            if (w_ld_c) r_c <= in_data;
            // Set beats clear when both happen together.
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
            if (!e_oe) r_e_in <= e;
        end
    end

endmodule

// File: tb/tb_triplet_loader.sv
// Bench for triplet_loader: a byte-count model plus directed scenarios.
module tb_triplet_loader;

    localparam int unsigned DW  = 8;
    localparam int unsigned TMO = 16;
    localparam int unsigned CW  = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic [DW-1:0] a, b, c;
    logic          out_valid;
    logic          out_ready;
    logic          err;
    logic          err_clr;
    logic          e_oe;
    wire  [1:0]    e;
    logic [1:0]    e_in;
    logic          tb_e_en;
    logic [1:0]    tb_e_val;

    assign e = tb_e_en ? tb_e_val : 2'bzz;

    triplet_loader #(.DW(DW), .TMO(TMO), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err),
        .err_clr   (err_clr),
        .e_oe      (e_oe),
        .e         (e),
        .e_in      (e_in)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_hs     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: number of bytes held, a full-triplet flag and an idle counter.
    int            m_n;
    logic          m_full;
    logic [DW-1:0] m_a, m_b, m_c;
    int            m_idle;
    logic          m_err;
    logic [1:0]    m_ein;
    logic          m_set;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n = 0; m_full = 1'b0; m_a = '0; m_b = '0; m_c = '0;
            m_idle = 0; m_err = 1'b0; m_ein = 2'b00;
        end else begin
            m_set = 1'b0;
            if (m_full) begin
                if (out_ready) m_full = 1'b0;
            end else if (in_valid) begin
                case (m_n)
                    0:       m_a = in_data;
                    1:       m_b = in_data;
                    default: m_c = in_data;
                endcase
                m_idle = 0;
                if (m_n == 2) begin
                    m_full = 1'b1;
                    m_n    = 0;
                end else begin
                    m_n++;
                end
            end else if (m_n != 0) begin
                if (m_idle == int'(TMO)) begin
                    m_n    = 0;
                    m_idle = 0;
                    m_set  = 1'b1;
                end else begin
                    m_idle++;
                end
            end
            if (m_set) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
            if (!e_oe) m_ein = tb_e_val;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", in_ready, !m_full);
            chk("out_valid", out_valid, m_full);
            chk("a", a, m_a);
            chk("b", b, m_b);
            chk("c", c, m_c);
            chk("err", err, m_err);
            chk("e_in", e_in, m_ein);
            if (e_oe) chk("e_code", e, m_full ? 32'd3 : 32'(m_n));
        end
    end

    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) n_hs++;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send(input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        cyc(1);
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int hs0;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        err_clr = 1'b0; e_oe = 1'b0; tb_e_en = 1'b1; tb_e_val = 2'b00;
        cyc(2);
        chk("rst_a", a, 8'h00);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_err", err, 1'b0);
        chk("rst_e_in", e_in, 2'b00);
        rst_n = 1'b1;
        cyc(1);

        // Basic triplet with immediate drain.
        out_ready = 1'b1;
        send(8'h11); send(8'h22); send(8'h33);
        chk("t1_ov", out_valid, 1'b1);
        chk("t1_ir", in_ready, 1'b0);
        chk("t1_a", a, 8'h11);
        chk("t1_b", b, 8'h22);
        chk("t1_c", c, 8'h33);
        cyc(1);
        chk("t1_ov_once", out_valid, 1'b0);
        chk("t1_a_hold", a, 8'h11);

        // Backpressure for 10 cycles, byte waiting during the FULL cycle.
        out_ready = 1'b0;
        send(8'hAA); send(8'hBB); send(8'hCC);
        cyc(10);
        chk("t2_ov_held", out_valid, 1'b1);
        chk("t2_c_held", c, 8'hCC);
        in_valid = 1'b1; in_data = 8'h44; out_ready = 1'b1;
        cyc(1);
        chk("t2_drained", out_valid, 1'b0);
        chk("t2_a_not_taken", a, 8'hAA);
        cyc(1);
        chk("t2_next_byte", a, 8'h44);
        send(8'h55); send(8'h66);
        cyc(1);

        // Timeout of a single byte, then clean triplet.
        out_ready = 1'b0;
        send(8'h5A);
        cyc(int'(TMO));
        chk("t3_no_err_yet", err, 1'b0);
        cyc(1);
        chk("t3_err", err, 1'b1);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        chk("t3_err_clr", err, 1'b0);
        send(8'h01); send(8'h02); send(8'h03);
        chk("t3_a", a, 8'h01);
        chk("t3_b", b, 8'h02);
        chk("t3_c", c, 8'h03);
        out_ready = 1'b1;
        cyc(1);
        out_ready = 1'b0;

        // Accept on the expiry cycle wins; set beats clear.
        send(8'h10);
        cyc(int'(TMO));
        send(8'h20);
        chk("t4_accept_wins", err, 1'b0);
        chk("t4_b", b, 8'h20);
        cyc(int'(TMO));
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        chk("t4_set_wins", err, 1'b1);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;

        // Debug bus walk and external drive.
        tb_e_en = 1'b0; e_oe = 1'b1;
        #1 chk("t5_e0", e, 2'b00);
        cyc(1);
        send(8'h07); chk("t5_e1", e, 2'b01);
        send(8'h08); chk("t5_e2", e, 2'b10);
        send(8'h09); chk("t5_e3", e, 2'b11);
        out_ready = 1'b1;
        cyc(1);
        chk("t5_e_back", e, 2'b00);
        out_ready = 1'b0;
        e_oe = 1'b0; tb_e_en = 1'b1; tb_e_val = 2'b10;
        #1 chk("t5_ext_e", e, 2'b10);
        cyc(1);
        chk("t5_e_in", e_in, 2'b10);

        // Reset in HAVE_B, then one clean triplet.
        send(8'h77); send(8'h88);
        rst_n = 1'b0;
        #1;
        chk("t6_a", a, 8'h00);
        chk("t6_b", b, 8'h00);
        chk("t6_ov", out_valid, 1'b0);
        chk("t6_ir", in_ready, 1'b1);
        chk("t6_err", err, 1'b0);
        chk("t6_e_in", e_in, 2'b00);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        hs0 = n_hs;
        out_ready = 1'b1;
        send(8'h01); send(8'h02); send(8'h03);
        cyc(3);
        chk("t6_one_triplet", 32'(n_hs - hs0), 32'd1);
        chk("t6_a_final", a, 8'h01);
        chk("t6_c_final", c, 8'h03);

        cyc(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
